// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for the multiply sequencer: FSM states and the 2-bit ALU
// control codes, which the main instruction decoder also uses.
package alu_mul_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // {N,Z} of a result; C and V are deliberately not produced for multiplies.
  function automatic logic [1:0] nz_flags_of(input logic [DATA_W-1:0] value);
    return {value[DATA_W-1], (value == {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/alu_mul_seq_mul_iter_dp.sv
// Shift-add iteration registers: accumulator, shifting multiplicand,
// shifting multiplier and iteration counter.
module alu_mul_seq_mul_iter_dp #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_accumulate,
  input  logic [WIDTH-1:0] i_rn,
  input  logic [WIDTH-1:0] i_rm,
  input  logic [WIDTH-1:0] i_ra,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0] o_mplr,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [CNT_W-1:0] r_count;

  // The ALU sum is only taken when the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= {WIDTH{1'b0}};
      r_mcand <= {WIDTH{1'b0}};
      r_mplr  <= {WIDTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_acc   <= i_accumulate ? i_ra : {WIDTH{1'b0}};
      r_mcand <= i_rn;
      r_mplr  <= i_rm;
      r_count <= {CNT_W{1'b0}};
    end else if (i_step) begin
      r_acc   <= r_mplr[0] ? i_alu_result : r_acc;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_acc   = r_acc;
  assign o_mcand = r_mcand;
  assign o_mplr  = r_mplr;
  assign o_count = r_count;

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle MUL/MLA sequencer: drives the shared ALU with add operations
// while busy and publishes the low product word with its N/Z flags.
module alu_mul_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] ra,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [1:0]       nz_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  import alu_mul_seq_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_mcand;
  logic [WIDTH-1:0] w_mplr;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] r_product;
  logic [1:0]       r_nz_flags;

  alu_mul_seq_mul_iter_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_dp (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_accumulate (accumulate),
    .i_rn         (rn),
    .i_rm         (rm),
    .i_ra         (ra),
    .i_alu_result (alu_result),
    .o_acc        (w_acc),
    .o_mcand      (w_mcand),
    .o_mplr       (w_mplr),
    .o_count      (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, iteration control and ALU operand drive.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_alu_a     = {WIDTH{1'b0}};
    w_alu_b     = {WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (EARLY_TERM && (rm == {WIDTH{1'b0}})) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_step  = 1'b1;
        w_alu_a = w_acc;
        w_alu_b = w_mcand;
        if ((EARLY_TERM && ((w_mplr >> 1) == {WIDTH{1'b0}})) || (w_count == LAST_ITER)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Result is captured on the DONE->IDLE edge and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_product  <= {WIDTH{1'b0}};
      r_nz_flags <= 2'b00;
    end else if (r_state == ST_DONE) begin
      r_product  <= w_acc;
      r_nz_flags <= nz_flags_of(w_acc);
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign product  = r_product;
  assign nz_flags = r_nz_flags;
  assign alu_a    = w_alu_a;
  assign alu_b    = w_alu_b;
  assign alu_ctrl = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench: two sequencers (early termination on and off) share stimulus,
// each driving its own behavioural 2-bit-control ALU.
module tb_alu_mul_seq;

  typedef struct {
    logic        acc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] ra;
    logic [31:0] exp_prod;
    logic [1:0]  exp_nz;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] rn = 32'd0;
  logic [31:0] rm = 32'd0;
  logic [31:0] ra = 32'd0;

  logic        busy1, done1, busy0, done0;
  logic [31:0] prod1, prod0, a1, b1, a0, b0, res1, res0;
  logic [1:0]  nz1, nz0, ctrl1, ctrl0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign res1 = alu_model(a1, b1, ctrl1);
  assign res0 = alu_model(a0, b0, ctrl0);

  alu_mul_seq #(.WIDTH(32), .EARLY_TERM(1'b1)) dut_et1 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .rn(rn), .rm(rm), .ra(ra), .busy(busy1), .done(done1),
    .product(prod1), .nz_flags(nz1), .alu_a(a1), .alu_b(b1),
    .alu_ctrl(ctrl1), .alu_result(res1)
  );

  alu_mul_seq #(.WIDTH(32), .EARLY_TERM(1'b0)) dut_et0 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .rn(rn), .rm(rm), .ra(ra), .busy(busy0), .done(done0),
    .product(prod0), .nz_flags(nz0), .alu_a(a0), .alu_b(b0),
    .alu_ctrl(ctrl0), .alu_result(res0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ALU control is always add; operands are zero whenever the ALU is not in use.
  always @(negedge clk) begin
    if (!reset) begin
      chk("alu_ctrl et1", {30'd0, ctrl1}, 32'd0);
      chk("alu_ctrl et0", {30'd0, ctrl0}, 32'd0);
      if (!busy1 || done1) chk("alu_a|b idle et1", a1 | b1, 32'd0);
      if (!busy0 || done0) chk("alu_a|b idle et0", a0 | b0, 32'd0);
    end
  end

  task automatic do_op(input vec_t v, input int poke_k, input string nm);
    int lat1, lat0;
    bit got1, got0;
    logic [31:0] p1, p0;
    logic [1:0]  f1, f0;
    lat1 = 0; lat0 = 0; got1 = 1'b0; got0 = 1'b0;
    p1 = ~v.exp_prod; p0 = ~v.exp_prod; f1 = ~v.exp_nz; f0 = ~v.exp_nz;
    @(negedge clk);
    start = 1'b1; accumulate = v.acc; rn = v.rn; rm = v.rm; ra = v.ra;
    for (int k = 1; k <= 40 && !(got1 && got0); k++) begin
      @(negedge clk);
      start = (k == poke_k);
      if (k == poke_k) begin
        accumulate = 1'b0; rn = 32'd2; rm = 32'd2; ra = 32'd0;
      end
      if (lat1 != 0 && !got1) begin
        got1 = 1'b1; p1 = prod1; f1 = nz1;
        chk({nm, " done1 pulse width"}, {31'd0, done1}, 32'd0);
        chk({nm, " busy1 after done"}, {31'd0, busy1}, 32'd0);
      end else if (done1 && lat1 == 0) begin
        lat1 = k;
      end
      if (lat0 != 0 && !got0) begin
        got0 = 1'b1; p0 = prod0; f0 = nz0;
      end else if (done0 && lat0 == 0) begin
        lat0 = k;
      end
    end
    start = 1'b0;
    chk({nm, " latency et1"}, lat1, v.exp_lat);
    chk({nm, " product et1"}, p1, v.exp_prod);
    chk({nm, " nz et1"}, {30'd0, f1}, {30'd0, v.exp_nz});
    chk({nm, " latency et0"}, lat0, 33);
    chk({nm, " product et0"}, p0, v.exp_prod);
    chk({nm, " nz et0"}, {30'd0, f0}, {30'd0, v.exp_nz});
  endtask

  vec_t tv[11];

  initial begin
    tv[0]  = '{1'b0, 32'd7,         32'd6,         32'd0,         32'd42,        2'b00, 4};
    tv[1]  = '{1'b1, 32'd5,         32'd3,         32'd100,       32'd115,       2'b00, 3};
    tv[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'h00000001,  2'b00, 33};
    tv[3]  = '{1'b0, 32'h80000000,  32'd1,         32'd0,         32'h80000000,  2'b10, 2};
    tv[4]  = '{1'b0, 32'd1234,      32'd0,         32'd0,         32'd0,         2'b01, 1};
    tv[5]  = '{1'b1, 32'd1234,      32'd0,         32'd9,         32'd9,         2'b00, 1};
    tv[6]  = '{1'b0, 32'd3,         32'd2,         32'd0,         32'd6,         2'b00, 3};
    tv[7]  = '{1'b1, 32'h10,        32'h10,        32'hFFFFFF00,  32'd0,         2'b01, 6};
    tv[8]  = '{1'b0, 32'hFFFFFFFD,  32'd5,         32'd0,         32'hFFFFFFF1,  2'b10, 4};
    tv[9]  = '{1'b0, 32'h12345678,  32'h100,       32'd0,         32'h34567800,  2'b00, 10};
    tv[10] = '{1'b0, 32'd2,         32'd2,         32'h0000DEAD,  32'd4,         2'b00, 3};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset busy1", {31'd0, busy1}, 32'd0);
    chk("reset done1", {31'd0, done1}, 32'd0);
    chk("reset product1", prod1, 32'd0);
    chk("reset nz1", {30'd0, nz1}, 32'd0);
    chk("reset busy0", {31'd0, busy0}, 32'd0);
    chk("reset product0", prod0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(tv[i], 0, $sformatf("vec%0d", i));
    end

    // start pulsed mid-CALC is ignored.
    do_op(tv[2], 5, "midstart");

    // Back-to-back: restart in the first IDLE cycle after done.
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0; rn = 32'd7; rm = 32'd6; ra = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) chk("b2b done1 first", {31'd0, done1}, 32'd1);
      if (k == 5) begin
        chk("b2b product1 first", prod1, 32'd42);
        chk("b2b busy1 idle", {31'd0, busy1}, 32'd0);
        start = 1'b1; accumulate = 1'b1; rn = 32'd5; rm = 32'd3; ra = 32'd100;
      end
      if (k == 6) start = 1'b0;
      if (k == 8) chk("b2b done1 second", {31'd0, done1}, 32'd1);
      if (k == 9) begin
        chk("b2b product1 second", prod1, 32'd115);
        chk("b2b nz1 second", {30'd0, nz1}, 32'd0);
      end
    end
    for (int k = 0; k < 40 && busy0; k++) @(negedge clk);
    chk("b2b et0 drained", {31'd0, busy0}, 32'd0);
    chk("b2b product0 kept first", prod0, 32'd42);

    // Reset during CALC aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0; rn = 32'd7; rm = 32'd6; ra = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("abort busy1 in calc", {31'd0, busy1}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy1", {31'd0, busy1}, 32'd0);
    chk("abort product1", prod1, 32'd0);
    chk("abort nz1", {30'd0, nz1}, 32'd0);
    chk("abort busy0", {31'd0, busy0}, 32'd0);
    chk("abort product0", prod0, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort no done1", {31'd0, done1}, 32'd0);
      chk("abort no done0", {31'd0, done0}, 32'd0);
    end

    do_op(tv[0], 0, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
